// File: rtl/dsp_mac_pkg.sv
// Shared constants for the MAC slice: opmode field positions and Z-mux encodings.
package dsp_mac_pkg;

    localparam int OPMODE_W  = 5;

    // Opmode bit positions
    localparam int PRE_EN    = 0;
    localparam int PRE_SUB   = 1;
    localparam int Z_SEL_LSB = 2;
    localparam int POST_SUB  = 4;

    // Post-adder Z operand select
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_C    = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// Operand/result bundle of the MAC slice. The master drives operands, the slave returns P.
interface dsp_mac_pipe_if
    import dsp_mac_pkg::*;
#(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int P_WIDTH = 48
) ();

    logic                in_valid;
    logic [OPMODE_W-1:0] opmode;
    logic [A_WIDTH-1:0]  A;
    logic [B_WIDTH-1:0]  B;
    logic [B_WIDTH-1:0]  D;
    logic [C_WIDTH-1:0]  C;
    logic [P_WIDTH-1:0]  P;
    logic                carry_out;
    logic                out_valid;

    modport master (
        output in_valid, opmode, A, B, D, C,
        input  P, carry_out, out_valid
    );

    modport slave (
        input  in_valid, opmode, A, B, D, C,
        output P, carry_out, out_valid
    );

endinterface

// File: rtl/dsp_pipe_reg.sv
// Generic pipeline register with clock enable and asynchronous clear.
module dsp_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, clear immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-add / multiply / post-add slice: P = Z +/- ((D +/- B) * A).
// Every register, P included, freezes while ce is low; P only moves on a valid result
// so accumulation chains are unaffected by bubbles.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int P_WIDTH = 48,
    parameter int SIGNED  = 0,
    parameter int MREG    = 1
) (
    input logic           clk,
    input logic           rst,
    input logic           ce,
    dsp_mac_pipe_if.slave bus
);

    localparam int M_W   = A_WIDTH + B_WIDTH;
    // Only opmode[4:2] is needed past the pre-adder.
    localparam int OPH_W = OPMODE_W - Z_SEL_LSB;
    localparam int PS_H  = POST_SUB - Z_SEL_LSB;
    localparam int S0_W  = A_WIDTH + 2 * B_WIDTH + C_WIDTH + OPMODE_W;
    localparam int S1_W  = B_WIDTH + A_WIDTH + C_WIDTH + OPH_W;
    localparam int S2_W  = M_W + C_WIDTH + OPH_W;

    function automatic logic [P_WIDTH-1:0] ext_m(input logic [M_W-1:0] m);
        if (SIGNED != 0) ext_m = P_WIDTH'($signed(m));
        else             ext_m = P_WIDTH'(m);
    endfunction

    function automatic logic [P_WIDTH-1:0] ext_c(input logic [C_WIDTH-1:0] c);
        if (SIGNED != 0) ext_c = P_WIDTH'($signed(c));
        else             ext_c = P_WIDTH'(c);
    endfunction

    // ---- stage p0: input capture ----
    logic [S0_W-1:0]     s0_q;
    logic [A_WIDTH-1:0]  a_p0;
    logic [B_WIDTH-1:0]  b_p0, d_p0;
    logic [C_WIDTH-1:0]  c_p0;
    logic [OPMODE_W-1:0] op_p0;
    logic                vld_p0;

    dsp_pipe_reg #(.WIDTH(S0_W)) u_s0 (
        .clk(clk), .rst(rst), .en(ce),
        .d({bus.A, bus.B, bus.D, bus.C, bus.opmode}), .q(s0_q)
    );
    dsp_pipe_reg #(.WIDTH(1)) u_v0 (
        .clk(clk), .rst(rst), .en(ce), .d(bus.in_valid), .q(vld_p0)
    );
    assign {a_p0, b_p0, d_p0, c_p0, op_p0} = s0_q;

    // ---- stage p1: pre-adder (wraps at B_WIDTH) ----
    logic [B_WIDTH-1:0] pre;
    logic [S1_W-1:0]    s1_q;
    logic [B_WIDTH-1:0] pre_p1;
    logic [A_WIDTH-1:0] a_p1;
    logic [C_WIDTH-1:0] c_p1;
    logic [OPH_W-1:0]   oph_p1;
    logic               vld_p1;

    // Pre-adder: pass B, or D+B / D-B when enabled.
    always_comb begin
        pre = b_p0;
        if (op_p0[PRE_EN]) begin
            pre = op_p0[PRE_SUB] ? (d_p0 - b_p0) : (d_p0 + b_p0);
        end
    end

    dsp_pipe_reg #(.WIDTH(S1_W)) u_s1 (
        .clk(clk), .rst(rst), .en(ce),
        .d({pre, a_p0, c_p0, op_p0[OPMODE_W-1:Z_SEL_LSB]}), .q(s1_q)
    );
    dsp_pipe_reg #(.WIDTH(1)) u_v1 (
        .clk(clk), .rst(rst), .en(ce), .d(vld_p0), .q(vld_p1)
    );
    assign {pre_p1, a_p1, c_p1, oph_p1} = s1_q;

    // ---- stage p2: multiplier, optionally registered ----
    logic [M_W-1:0]     m_comb;
    logic [M_W-1:0]     m_p2;
    logic [C_WIDTH-1:0] c_p2;
    logic [OPH_W-1:0]   oph_p2;
    logic               vld_p2;

    generate
        if (SIGNED != 0) begin : g_smul
            logic signed [M_W-1:0] prod_s;
            assign prod_s = M_W'($signed(pre_p1)) * M_W'($signed(a_p1));
            assign m_comb = prod_s;
        end else begin : g_umul
            assign m_comb = M_W'(pre_p1) * M_W'(a_p1);
        end

        if (MREG != 0) begin : g_mreg
            logic [S2_W-1:0] s2_q;
            dsp_pipe_reg #(.WIDTH(S2_W)) u_s2 (
                .clk(clk), .rst(rst), .en(ce),
                .d({m_comb, c_p1, oph_p1}), .q(s2_q)
            );
            dsp_pipe_reg #(.WIDTH(1)) u_v2 (
                .clk(clk), .rst(rst), .en(ce), .d(vld_p1), .q(vld_p2)
            );
            assign {m_p2, c_p2, oph_p2} = s2_q;
        end else begin : g_nomreg
            assign m_p2   = m_comb;
            assign c_p2   = c_p1;
            assign oph_p2 = oph_p1;
            assign vld_p2 = vld_p1;
        end
    endgenerate

    // ---- stage p3: post-adder and P register ----
    logic [P_WIDTH-1:0] z;
    logic [P_WIDTH-1:0] mx;
    logic [P_WIDTH:0]   res;
    logic [P_WIDTH:0]   pq_p3;
    logic [P_WIDTH-1:0] p_p3;
    logic               carry_p3;
    logic               vld_p3;

    // Z mux and post add/sub in P_WIDTH+1 bits so the top bit is carry/borrow.
    always_comb begin
        z = '0;
        case (oph_p2[1:0])
            Z_C:     z = ext_c(c_p2);
            Z_P:     z = p_p3;
            default: z = '0;
        endcase
        mx  = ext_m(m_p2);
        res = oph_p2[PS_H] ? ({1'b0, z} - {1'b0, mx}) : ({1'b0, z} + {1'b0, mx});
    end

    dsp_pipe_reg #(.WIDTH(P_WIDTH + 1)) u_s3 (
        .clk(clk), .rst(rst), .en(ce & vld_p2), .d(res), .q(pq_p3)
    );
    dsp_pipe_reg #(.WIDTH(1)) u_v3 (
        .clk(clk), .rst(rst), .en(ce), .d(vld_p2), .q(vld_p3)
    );
    assign p_p3     = pq_p3[P_WIDTH-1:0];
    assign carry_p3 = pq_p3[P_WIDTH];

    assign bus.P         = p_p3;
    assign bus.carry_out = carry_p3;
    assign bus.out_valid = vld_p3;

endmodule
